// File: rtl/mult_booth_ctrl.sv
// Radix-2 Booth multiplier controller: 32x32 signed operands, 32 iterations.
// Optional overflow detection is compiled in when MULT_OVF_DETECT_EN is defined;
// otherwise data_exception is tied low.
module mult_booth_ctrl (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ctrl_MULT,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state;
  logic [32:0] m_reg;
  logic [65:0] p_reg;
  logic [4:0]  cnt;

  logic [32:0] upper_sum;
  logic [65:0] p_next;
`ifdef MULT_OVF_DETECT_EN
  logic        ovf;
`endif

  // Booth step: add/subtract M into the upper 33 bits, then arithmetic shift right.
  always_comb begin
    upper_sum = p_reg[65:33];
    unique case (p_reg[1:0])
      2'b01:   upper_sum = p_reg[65:33] + m_reg;
      2'b10:   upper_sum = p_reg[65:33] - m_reg;
      default: upper_sum = p_reg[65:33];
    endcase
    p_next = {upper_sum[32], upper_sum, p_reg[32:1]};
  end

`ifdef MULT_OVF_DETECT_EN
  // Product bits 63:31 must all match for the result to fit in 32 signed bits.
  always_comb begin
    ovf = (p_next[64:32] != 33'h0) && (p_next[64:32] != {33{1'b1}});
  end
`else
  assign data_exception = 1'b0;
`endif

  // Controller FSM with registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= StIdle;
      m_reg          <= 33'h0;
      p_reg          <= 66'h0;
      cnt            <= 5'd0;
      data_result    <= 32'h0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
`ifdef MULT_OVF_DETECT_EN
      data_exception <= 1'b0;
`endif
    end else begin
      unique case (state)
        StIdle, StDone: begin
          data_resultRDY <= 1'b0;
          if (ctrl_MULT) begin
            m_reg <= {data_operandA[31], data_operandA};
            p_reg <= {33'h0, data_operandB, 1'b0};
            cnt   <= 5'd0;
            busy  <= 1'b1;
            state <= StRun;
          end else begin
            state <= StIdle;
          end
        end
        StRun: begin
          // Start requests are ignored while iterating.
          p_reg <= p_next;
          cnt   <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state          <= StDone;
            busy           <= 1'b0;
            data_resultRDY <= 1'b1;
            data_result    <= p_next[32:1];
`ifdef MULT_OVF_DETECT_EN
            data_exception <= ovf;
`endif
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_booth_ctrl.sv
// Scoreboard bench for mult_booth_ctrl: randomized and directed starts checked
// against a plain 64-bit signed multiply reference.
module tb_mult_booth_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        ctrl_MULT = 1'b0;
  logic [31:0] data_operandA = 32'h0;
  logic [31:0] data_operandB = 32'h0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  mult_booth_ctrl dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  int   busy_until = 0;
  int   last_acc = 0;

  // Count of rising edges seen so far.
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
  endfunction

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input int due);
    exp_t r;
    logic signed [63:0] pr;
    pr = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
    r.res = pr[31:0];
    r.exc = (pr[63:31] != 33'h0) && (pr[63:31] != {33{1'b1}});
`ifndef MULT_OVF_DETECT_EN
    r.exc = 1'b0;
`endif
    r.due = due;
    return r;
  endfunction

  // Monitor: busy every cycle, and each RDY pulse against the scoreboard head.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n) begin
      chk("busy", {63'h0, busy}, {63'h0, (cyc >= last_acc) && (cyc < busy_until)});
      if (q.size() > 0 && q[0].due < cyc) begin
        chk("rdy_missed", 64'd0, 64'd1);
        void'(q.pop_front());
      end
      if (data_resultRDY) begin
        if (q.size() == 0) begin
          chk("rdy_spurious", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("rdy_cycle", 64'(cyc), 64'(e.due));
          chk("result", {32'h0, data_result}, {32'h0, e.res});
          chk("exception", {63'h0, data_exception}, {63'h0, e.exc});
        end
      end
    end
  end

  // Called just after a falling edge; holds the request for one cycle.
  task automatic issue(input logic [31:0] ai, input logic [31:0] bi);
    int k;
    k = cyc;
    if (k >= busy_until) begin
      q.push_back(model(ai, bi, k + 33));
      last_acc   = k + 1;
      busy_until = k + 33;
    end
    data_operandA = ai;
    data_operandB = bi;
    ctrl_MULT     = 1'b1;
    @(negedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_cyc(input int k);
    while (cyc < k) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_result", {32'h0, data_result}, 64'd0);
    chk("rst_exception", {63'h0, data_exception}, 64'd0);
    chk("rst_rdy", {63'h0, data_resultRDY}, 64'd0);
    chk("rst_busy", {63'h0, busy}, 64'd0);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    q.delete();
    busy_until = cyc;
    last_acc   = cyc;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clock);
    #2;
    reset_n = 1'b1;
    @(negedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    #1 reset_n = 1'b0;
    #2 check_reset_outputs();
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
    #1;

    issue(32'd3, 32'd4);                 wait_cyc(busy_until + 2);
    issue(32'hFFFF_FFF9, 32'd6);         wait_cyc(busy_until + 1);
    issue(32'h8000_0000, 32'hFFFF_FFFF); wait_cyc(busy_until + 2);
    issue(32'h7FFF_FFFF, 32'd2);         wait_cyc(busy_until + 1);
    issue(32'h8000_0000, 32'h8000_0000); wait_cyc(busy_until + 3);

    // Start during RUN is ignored.
    issue(32'd5, 32'd5);
    wait_cyc(last_acc + 10);
    issue(32'd9, 32'd9);
    wait_cyc(busy_until + 2);

    // Reset mid-run abandons the operation.
    issue(32'd5, 32'd5);
    wait_cyc(last_acc + 10);
    apply_reset();
    issue(32'd2, 32'd3);
    wait_cyc(busy_until);

    // Start accepted in the DONE cycle.
    issue(32'd4, 32'd5);
    wait_cyc(busy_until + 2);
    issue(32'd2, 32'd3);
    wait_cyc(busy_until);
    issue(32'd4, 32'd5);
    wait_cyc(busy_until + 2);

    for (int i = 0; i < 25; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) ra = $urandom_range(0, 200) - 100;
      if (i % 3 == 2) rb = $urandom_range(0, 200) - 100;
      issue(ra, rb);
      if ($urandom_range(0, 2) == 0) begin
        wait_cyc(last_acc + int'($urandom_range(1, 30)));
        issue($urandom, $urandom);
      end
      wait_cyc(busy_until + int'($urandom_range(0, 3)));
    end

    wait_cyc(busy_until + 3);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mult_booth_ctrl.md
MULT_BOOTH_CTRL -- requirements
Module: mult_booth_ctrl

Interface
REQ-001 Parameters: none; operand width fixed at 32, product register fixed at 66 bits, iteration count fixed at 32.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 ctrl_MULT  input  1  start request, sampled on rising edge.
REQ-005 data_operandA  input  32  multiplicand M, signed two's complement.
REQ-006 data_operandB  input  32  multiplier Q, signed two's complement.
REQ-007 data_result  output  32  low 32 bits of signed product.
REQ-008 data_exception  output  1  product not representable in 32 signed bits.
REQ-009 data_resultRDY  output  1  one-cycle completion pulse.
REQ-010 busy  output  1  high while iterating.

Function
REQ-011 The FSM SHALL have states IDLE, RUN, DONE.
REQ-012 In IDLE or DONE, ctrl_MULT=1 at an edge SHALL capture M (sign-extended to 33 bits), load P = {33'b0, Q, 1'b0}, clear the 5-bit iteration counter, and enter RUN.
REQ-013 Each RUN edge SHALL examine P[1:0]: 01 -> P[65:33] += M; 10 -> P[65:33] -= M; 00/11 -> no add. Addition is 33-bit modulo.
REQ-014 In the same edge, the post-add P SHALL be arithmetically shifted right by 1, sign bit P[65] replicated, and the counter incremented.
REQ-015 After the 32nd RUN edge (counter wraps 31->0), the FSM SHALL enter DONE.
REQ-016 Edge 0 samples ctrl_MULT; edges 1..32 iterate; data_resultRDY SHALL be high only in the cycle following edge 32.
REQ-017 data_result SHALL equal P[32:1] from edge 32 onward and SHALL hold until the next accepted start.
REQ-018 data_exception SHALL be 1 iff P[64:32] is not all-zeros or all-ones; it is valid alongside data_result.
REQ-019 busy SHALL be 1 exactly in RUN.
REQ-020 ctrl_MULT during RUN SHALL be ignored; operands and progress are unaffected.
REQ-021 ctrl_MULT in the DONE cycle SHALL be accepted. data_resultRDY still pulses that cycle, and RUN follows.
REQ-022 Without a start, DONE SHALL return to IDLE after one cycle, and outputs hold.
REQ-023 Operand inputs SHALL be don't-care except at the accepting edge.

Reset
REQ-024 reset_n=0 SHALL immediately force IDLE, P=0, M=0, counter=0, data_result=0, data_exception=0, data_resultRDY=0, busy=0.
REQ-025 Reset mid-RUN SHALL abandon the operation, and no data_resultRDY pulse SHALL follow.
REQ-026 After reset_n deasserts, the first accepted start SHALL behave per REQ-012.

Configuration
REQ-027 Macro MULT_OVF_DETECT_EN: defined -> data_exception per REQ-018; undefined -> data_exception is constant 0 and the overflow compare logic is removed.

Verification
REQ-028 Start with A=3, B=4 -> busy for 32 cycles, RDY pulse once, result=0x0000000C, exception=0.
REQ-029 A=-7, B=6 -> result=0xFFFFFFD6, exception=0; A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exception=1 (0 if macro undefined).
REQ-030 A=0x7FFFFFFF, B=2 -> result=0xFFFFFFFE, exception=1; A=0x80000000, B=0x80000000 -> result=0x00000000, exception=1.
REQ-031 Start 5x5, pulse ctrl_MULT with A=9, B=9 at RUN cycle 10 -> result=25 at original timing, no restart.
REQ-032 Start 5x5, assert reset_n=0 at RUN cycle 10 -> all outputs 0 immediately, no RDY; a new start 2x3 -> result=6 after 32 cycles.
REQ-033 Start 2x3, with a new start 4x5 in the DONE cycle -> RDY with 6, busy the next cycle, then RDY with 20 exactly 32 edges later.
